// File: rtl/transport_send_if.sv
// transport_send_if: session-write and network-byte handshake bundle for the
// transport transmitter. The master side drives session commands and network
// back-pressure. The slave side is the transmitter itself.
interface transport_send_if;
    logic [1:0]  sessionSend;
    logic [15:0] sessionData;
    logic        networkBusy;
    logic        transportBusy;
    logic        sendSignal;
    logic [7:0]  packetOut;

    modport master (
        output sessionSend,
        output sessionData,
        output networkBusy,
        input  transportBusy,
        input  sendSignal,
        input  packetOut
    );

    modport slave (
        input  sessionSend,
        input  sessionData,
        input  networkBusy,
        output transportBusy,
        output sendSignal,
        output packetOut
    );
endinterface

// File: rtl/transport_send.sv
// transport_send: transmit half of the transport layer.
// Audio words are queued in a FIFO. Control words sit in a one-entry register.
// Packets are framed as a header byte {1, type, seq}, followed by payload words
// sent high byte first. One byte is presented per cycle, under networkBusy
// back-pressure.
// Optional feature macro: TRANSPORT_CHECKSUM_EN. When it is defined, the packet
// gains one trailing byte, which is the XOR of the header and all payload bytes.
module transport_send #(
    parameter int PAYLOAD_WORDS = 4,
    parameter int FIFO_DEPTH    = 8
) (
    input logic             clk,
    input logic             reset,
    transport_send_if.slave bus
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] PAY_CNT  = CW'(PAYLOAD_WORDS);
    localparam logic [3:0]    PAY_LEN  = 4'(PAYLOAD_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PAY_HI = 2'd1,
        ST_PAY_LO = 2'd2
`ifdef TRANSPORT_CHECKSUM_EN
        , ST_CHK  = 2'd3
`endif
    } state_t;

    // Pointer advance with explicit wrap, so non-power-of-2 depths stay correct.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(FIFO_DEPTH - 1)) ? {AW{1'b0}} : p + AW'(1);
    endfunction

    state_t          r_state;
    state_t          w_next_state;
    logic [15:0]     r_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_ctrl_valid;
    logic [15:0]     r_ctrl_data;
    logic            r_is_ctrl;
    logic [3:0]      r_words_left;
    logic [4:0]      r_seq;
    logic            r_send;
    logic [7:0]      r_pkt;
`ifdef TRANSPORT_CHECKSUM_EN
    logic [7:0]      r_chk;
`endif

    logic            w_busy;
    logic            w_push;
    logic            w_ctrl_load;
    logic            w_pop;
    logic            w_ctrl_clr;
    logic            w_emit;
    logic            w_start;
    logic            w_start_ctrl;
    logic [7:0]      w_byte;
    logic [15:0]     w_cur_word;

    assign w_busy      = (r_count == FULL_CNT) || r_ctrl_valid;
    assign w_push      = (bus.sessionSend == 2'b01) && !w_busy;
    assign w_ctrl_load = (bus.sessionSend == 2'b10) && !w_busy;
    assign w_cur_word  = r_is_ctrl ? r_ctrl_data : r_mem[r_rd_ptr];

    assign bus.transportBusy = w_busy;
    assign bus.sendSignal    = r_send;
    assign bus.packetOut     = r_pkt;

    // Framing FSM: choose the byte for this state and decide whether it leaves this edge.
    always_comb begin
        w_next_state = r_state;
        w_emit       = 1'b0;
        w_byte       = 8'h00;
        w_pop        = 1'b0;
        w_ctrl_clr   = 1'b0;
        w_start      = 1'b0;
        w_start_ctrl = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Control wins the tie, but only here; a running packet is never preempted.
                if (r_ctrl_valid) begin
                    w_start      = 1'b1;
                    w_start_ctrl = 1'b1;
                    w_byte       = {1'b1, 2'b10, r_seq};
                end else if (r_count >= PAY_CNT) begin
                    w_start = 1'b1;
                    w_byte  = {1'b1, 2'b01, r_seq};
                end else begin
                    w_start = 1'b0;
                end
                if (w_start && !bus.networkBusy) begin
                    w_emit       = 1'b1;
                    w_next_state = ST_PAY_HI;
                end else begin
                    w_next_state = r_state;
                end
            end
            ST_PAY_HI: begin
                w_byte = w_cur_word[15:8];
                if (!bus.networkBusy) begin
                    w_emit       = 1'b1;
                    w_next_state = ST_PAY_LO;
                end else begin
                    w_next_state = r_state;
                end
            end
            ST_PAY_LO: begin
                w_byte = w_cur_word[7:0];
                if (!bus.networkBusy) begin
                    w_emit = 1'b1;
                    if (r_is_ctrl) begin
                        w_ctrl_clr = 1'b1;
                    end else begin
                        w_pop = 1'b1;
                    end
                    if (r_words_left == 4'd1) begin
`ifdef TRANSPORT_CHECKSUM_EN
                        w_next_state = ST_CHK;
`else
                        w_next_state = ST_IDLE;
`endif
                    end else begin
                        w_next_state = ST_PAY_HI;
                    end
                end else begin
                    w_next_state = r_state;
                end
            end
`ifdef TRANSPORT_CHECKSUM_EN
            ST_CHK: begin
                w_byte = r_chk;
                if (!bus.networkBusy) begin
                    w_emit       = 1'b1;
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = r_state;
                end
            end
`endif
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // State, packet bookkeeping and registered byte outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_is_ctrl    <= 1'b0;
            r_words_left <= 4'd0;
            r_seq        <= 5'd0;
            r_send       <= 1'b0;
            r_pkt        <= 8'h00;
        end else begin
            r_state <= w_next_state;
            r_send  <= w_emit;
            if (w_emit) begin
                r_pkt <= w_byte;
            end
            if (w_emit && (r_state == ST_IDLE)) begin
                r_seq        <= r_seq + 5'd1;
                r_is_ctrl    <= w_start_ctrl;
                r_words_left <= w_start_ctrl ? 4'd1 : PAY_LEN;
            end else if (w_emit && (r_state == ST_PAY_LO)) begin
                r_words_left <= r_words_left - 4'd1;
            end
        end
    end

`ifdef TRANSPORT_CHECKSUM_EN
    // Running XOR: the header seeds it, and every later byte of the packet folds in.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_chk <= 8'h00;
        end else if (w_emit && (r_state == ST_IDLE)) begin
            r_chk <= w_byte;
        end else if (w_emit) begin
            r_chk <= r_chk ^ w_byte;
        end
    end
`endif

    // FIFO storage; contents need no reset because the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.sessionData;
        end
    end

    // FIFO pointers and occupancy; a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {CW{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // One-entry control register: loads on an accepted control write, empties when its packet finishes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ctrl_valid <= 1'b0;
            r_ctrl_data  <= 16'h0000;
        end else if (w_ctrl_load) begin
            r_ctrl_valid <= 1'b1;
            r_ctrl_data  <= bus.sessionData;
        end else if (w_ctrl_clr) begin
            r_ctrl_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_transport_send.sv
// tb_transport_send: directed self-checking bench for transport_send.
// Expected packet bytes come from a small framing model fed with hand-chosen words.
module tb_transport_send;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    transport_send_if bus();

    transport_send #(.PAYLOAD_WORDS(4), .FIFO_DEPTH(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [7:0] cap [64];
    logic [7:0] exp_q [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.sessionSend = 2'b00;
        bus.sessionData = 16'h0000;
        bus.networkBusy = 1'b0;
    endtask

    task automatic write_word(input logic [1:0] cmd, input logic [15:0] d);
        bus.sessionSend = cmd;
        bus.sessionData = d;
        tick();
        bus.sessionSend = 2'b00;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        tick();
        tick();
        drive_idle();
        reset = 1'b1;
        tick();
    endtask

    // Framing model: appends the expected bytes of one packet to exp_q.
    task automatic model_packet(input logic [1:0] typ, input logic [4:0] seq,
                                input logic [15:0] w [8], input int nw);
        int base;
        base = exp_q.size();
        exp_q.push_back({1'b1, typ, seq});
        for (int i = 0; i < nw; i++) begin
            exp_q.push_back(w[i][15:8]);
            exp_q.push_back(w[i][7:0]);
        end
`ifdef TRANSPORT_CHECKSUM_EN
        begin
            logic [7:0] c;
            c = 8'h00;
            for (int i = base; i < exp_q.size(); i++) c = c ^ exp_q[i];
            exp_q.push_back(c);
        end
`endif
    endtask

    // Collects up to n strobed bytes within a cycle budget.
    task automatic capture(input int n, input int budget, output int got,
                           output int first_at, output int gaps);
        got = 0;
        first_at = -1;
        gaps = 0;
        for (int cyc = 1; cyc <= budget && got < n; cyc++) begin
            tick();
            if (bus.sendSignal === 1'b1) begin
                if (got < 64) cap[got] = bus.packetOut;
                if (got == 0) first_at = cyc;
                got++;
            end else if (got > 0) begin
                gaps++;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.sessionSend = 2'($urandom);
            bus.sessionData = 16'($urandom);
            bus.networkBusy = 1'($urandom);
            tick();
            checks++;
            if (bus.sendSignal !== 1'b0 || bus.packetOut !== 8'h00 || bus.transportBusy !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold: got send=%b pkt=%h busy=%b expected 0 00 0",
                         bus.sendSignal, bus.packetOut, bus.transportBusy);
            end
        end
        drive_idle();
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (bus.sendSignal !== 1'b0 || bus.transportBusy !== 1'b0) begin
                errors++;
                $display("FAIL reset_release_idle: got send=%b busy=%b expected 0 0",
                         bus.sendSignal, bus.transportBusy);
            end
        end
    endtask

    task automatic test_audio();
        logic [15:0] w [8];
        int got, first_at, gaps;
        w = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'h0, 16'h0, 16'h0, 16'h0};
        exp_q.delete();
        model_packet(2'b01, 5'd0, w, 4);
        for (int i = 0; i < 4; i++) write_word(2'b01, w[i]);
        capture(exp_q.size(), 40, got, first_at, gaps);
        checks++;
        if (got !== exp_q.size()) begin
            errors++;
            $display("FAIL audio_count: got %0d expected %0d", got, exp_q.size());
        end
        checks++;
        if (first_at !== 1) begin
            errors++;
            $display("FAIL audio_latency: got %0d expected 1", first_at);
        end
        checks++;
        if (gaps !== 0) begin
            errors++;
            $display("FAIL audio_gaps: got %0d expected 0", gaps);
        end
        for (int i = 0; i < got && i < exp_q.size(); i++) begin
            checks++;
            if (cap[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL audio_byte%0d: got %h expected %h", i, cap[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_stall();
        logic [15:0] w [8];
        int got, first_at, gaps, got2;
        w = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'h0, 16'h0, 16'h0, 16'h0};
        apply_reset();
        exp_q.delete();
        model_packet(2'b01, 5'd0, w, 4);
        for (int i = 0; i < 4; i++) write_word(2'b01, w[i]);
        capture(4, 40, got, first_at, gaps);
        checks++;
        if (got !== 4 || cap[3] !== 8'h56) begin
            errors++;
            $display("FAIL stall_pre: got %0d bytes last %h expected 4 bytes last 56", got, cap[3]);
        end
        bus.networkBusy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.sendSignal !== 1'b0 || bus.packetOut !== 8'h56) begin
                errors++;
                $display("FAIL stall_hold: got send=%b pkt=%h expected 0 56", bus.sendSignal, bus.packetOut);
            end
        end
        bus.networkBusy = 1'b0;
        capture(exp_q.size() - 4, 40, got2, first_at, gaps);
        checks++;
        if (got2 !== exp_q.size() - 4 || first_at !== 1 || gaps !== 0) begin
            errors++;
            $display("FAIL stall_resume: got n=%0d first=%0d gaps=%0d expected n=%0d first=1 gaps=0",
                     got2, first_at, gaps, exp_q.size() - 4);
        end
        for (int i = 0; i < got2 && i + 4 < exp_q.size(); i++) begin
            checks++;
            if (cap[i] !== exp_q[i + 4]) begin
                errors++;
                $display("FAIL stall_byte%0d: got %h expected %h", i + 4, cap[i], exp_q[i + 4]);
            end
        end
    endtask

    task automatic test_ctrl_priority();
        logic [15:0] wc [8];
        logic [15:0] wa [8];
        int got, first_at, gaps, quiet;
        wc = '{16'h00FF, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
        wa = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h0, 16'h0, 16'h0, 16'h0};
        exp_q.delete();
        model_packet(2'b10, 5'd1, wc, 1);
        write_word(2'b01, wa[0]);
        write_word(2'b01, wa[1]);
        write_word(2'b10, wc[0]);
        capture(exp_q.size(), 20, got, first_at, gaps);
        checks++;
        if (got !== exp_q.size() || first_at !== 1) begin
            errors++;
            $display("FAIL ctrl_count: got n=%0d first=%0d expected n=%0d first=1", got, first_at, exp_q.size());
        end
        for (int i = 0; i < got && i < exp_q.size(); i++) begin
            checks++;
            if (cap[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL ctrl_byte%0d: got %h expected %h", i, cap[i], exp_q[i]);
            end
        end
        quiet = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.sendSignal === 1'b1) quiet++;
        end
        checks++;
        if (quiet !== 0 || bus.transportBusy !== 1'b0) begin
            errors++;
            $display("FAIL ctrl_after_quiet: got strobes=%0d busy=%b expected 0 0", quiet, bus.transportBusy);
        end
        exp_q.delete();
        model_packet(2'b01, 5'd2, wa, 4);
        write_word(2'b01, wa[2]);
        write_word(2'b01, wa[3]);
        capture(exp_q.size(), 40, got, first_at, gaps);
        checks++;
        if (got !== exp_q.size() || first_at !== 1 || gaps !== 0) begin
            errors++;
            $display("FAIL ctrl_queued_audio: got n=%0d first=%0d gaps=%0d expected n=%0d 1 0",
                     got, first_at, gaps, exp_q.size());
        end
        for (int i = 0; i < got && i < exp_q.size(); i++) begin
            checks++;
            if (cap[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL queued_byte%0d: got %h expected %h", i, cap[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_full_fifo();
        logic [15:0] w0 [8];
        logic [15:0] w1 [8];
        int got, first_at, gaps, extra;
        w0 = '{16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0, 16'h0, 16'h0, 16'h0};
        w1 = '{16'h0505, 16'h0606, 16'h0707, 16'h0808, 16'h0, 16'h0, 16'h0, 16'h0};
        apply_reset();
        exp_q.delete();
        model_packet(2'b01, 5'd0, w0, 4);
        model_packet(2'b01, 5'd1, w1, 4);
        bus.networkBusy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            write_word(2'b01, (i < 4) ? w0[i] : w1[i - 4]);
            checks++;
            if (bus.transportBusy !== (i == 7)) begin
                errors++;
                $display("FAIL full_busy%0d: got %b expected %b", i, bus.transportBusy, (i == 7));
            end
        end
        write_word(2'b01, 16'h9999);
        checks++;
        if (bus.transportBusy !== 1'b1 || bus.sendSignal !== 1'b0) begin
            errors++;
            $display("FAIL full_ninth: got busy=%b send=%b expected 1 0", bus.transportBusy, bus.sendSignal);
        end
        bus.networkBusy = 1'b0;
        capture(exp_q.size(), 100, got, first_at, gaps);
        checks++;
        if (got !== exp_q.size() || first_at !== 1 || gaps !== 0) begin
            errors++;
            $display("FAIL full_drain: got n=%0d first=%0d gaps=%0d expected n=%0d 1 0",
                     got, first_at, gaps, exp_q.size());
        end
        for (int i = 0; i < got && i < exp_q.size(); i++) begin
            checks++;
            if (cap[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL full_byte%0d: got %h expected %h", i, cap[i], exp_q[i]);
            end
        end
        extra = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.sendSignal === 1'b1) extra++;
        end
        checks++;
        if (extra !== 0 || bus.transportBusy !== 1'b0) begin
            errors++;
            $display("FAIL full_empty_after: got strobes=%0d busy=%b expected 0 0", extra, bus.transportBusy);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] w [8];
        logic [15:0] wn [8];
        int got, first_at, gaps, extra;
        w  = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'h0, 16'h0, 16'h0, 16'h0};
        wn = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD, 16'h0, 16'h0, 16'h0, 16'h0};
        for (int i = 0; i < 4; i++) write_word(2'b01, w[i]);
        capture(3, 40, got, first_at, gaps);
        checks++;
        if (got !== 3 || cap[0] !== 8'hA2 || cap[2] !== 8'h34) begin
            errors++;
            $display("FAIL mid_pre: got n=%0d hdr=%h last=%h expected 3 A2 34", got, cap[0], cap[2]);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (bus.sendSignal !== 1'b0 || bus.packetOut !== 8'h00 || bus.transportBusy !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_async: got send=%b pkt=%h busy=%b expected 0 00 0",
                     bus.sendSignal, bus.packetOut, bus.transportBusy);
        end
        tick();
        drive_idle();
        reset = 1'b1;
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.sendSignal === 1'b1) extra++;
        end
        checks++;
        if (extra !== 0) begin
            errors++;
            $display("FAIL mid_no_resume: got strobes=%0d expected 0", extra);
        end
        exp_q.delete();
        model_packet(2'b01, 5'd0, wn, 4);
        for (int i = 0; i < 4; i++) write_word(2'b01, wn[i]);
        capture(exp_q.size(), 40, got, first_at, gaps);
        checks++;
        if (got !== exp_q.size() || first_at !== 1) begin
            errors++;
            $display("FAIL mid_new_pkt: got n=%0d first=%0d expected n=%0d 1", got, first_at, exp_q.size());
        end
        for (int i = 0; i < got && i < exp_q.size(); i++) begin
            checks++;
            if (cap[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL mid_byte%0d: got %h expected %h", i, cap[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        drive_idle();
        reset = 1'b0;
        test_reset();
        test_audio();
        test_stall();
        test_ctrl_priority();
        test_full_fifo();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
